serial_tx_port: RTL and testbench
=================================

// Module: serial_tx_port
// PURPOSE
//  Memory-mapped serial transmitter that sits downstream of the 8-bit CPU's output path.
//  A CPU store to the port address becomes a one-cycle WE strobe carrying the accumulator byte.
//  The byte is queued in a small FIFO and sent on TX as an 8N1 frame (start, 8 data LSB-first, stop).
//  This replaces bit-banging SERIAL_OUT in software; FULL/BUSY are returned to the CPU for polling.
// PARAMETERS
//  CLKS_PER_BIT  16  CLK cycles per serial bit; legal range 2..255
//  FIFO_DEPTH    4   queue entries; power of two, 2..16
//  DATA_WIDTH    8   payload bits per frame
// PORTS
//  CLK       in   1           system clock; all state updates on its rising edge
//  CLR       in   1           reset, synchronous, active-high
//  WE        in   1           write strobe, one cycle per byte (RAM_WE & port address decode)
//  DATA_IN   in   DATA_WIDTH  byte to queue; sampled only when WE=1
//  TX        out  1           serial line, idle high
//  FULL      out  1           FIFO holds FIFO_DEPTH entries
//  BUSY      out  1           frame in flight OR FIFO non-empty
//  OVERFLOW  out  1           sticky: a write arrived while FULL; cleared only by CLR
// BEHAVIOUR
//  Reset (CLR=1 at an edge): FIFO emptied, FSM->IDLE, TX=1, FULL=0, BUSY=0, OVERFLOW=0, counters=0.
//   A reset mid-frame aborts the frame immediately; TX is 1 from the next edge.
//  All outputs are registered or decoded from registers only; none depend combinationally on WE/DATA_IN.
//  FIFO:
//   - Push when WE=1 and FULL=0, with FULL taken from the pre-edge count.
//   - WE=1 with FULL=1 drops the byte and sets OVERFLOW, even if a pop happens in the same cycle.
//   - Push and pop in the same cycle: count is unchanged and the entry order is preserved.
//   - Pointers wrap modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits wide.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE:  TX=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud
//          counter and bit index, and go to START.
//   START: TX=0 for CLKS_PER_BIT cycles, then go to DATA.
//   DATA:  TX=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit.
//          After DATA_WIDTH bits, go to STOP.
//   STOP:  TX=1 for CLKS_PER_BIT cycles. If the FIFO is non-empty at the last stop cycle, pop and
//          go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
//  Baud counter: counts 0..CLKS_PER_BIT-1; bit advance happens when count==CLKS_PER_BIT-1.
//  Latency: WE at edge n into an empty FIFO with the FSM in IDLE -> pop at edge n+1 -> TX low
//   after edge n+1. One frame is exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
//  BUSY=1 from the edge after an accepted WE until the last STOP cycle with the FIFO empty.
//  FULL updates on the edge after the push that fills the FIFO.
// STRUCTURE
//  Package serial_tx_pkg:
//   - state encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3)
//   - TX_IDLE_LEVEL=1'b1
//  Sub-module sync_fifo #(WIDTH, DEPTH):
//   - ports CLK, CLR, push, din, pop, dout, full, empty
//   - synchronous reset; dout shows the head entry combinationally (show-ahead)
//  Top level: FSM, baud counter, bit index, shift register, OVERFLOW flag.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1. Reset, then WE with 8'hA5 -> TX low 2nd edge after WE; bits 1,0,1,0,0,1,0,1 then stop=1,
//     4 cycles each; BUSY falls after 40 frame cycles.
//  2. Five WE strobes on consecutive cycles (8'h01..8'h05) while IDLE -> first is popped
//     immediately; all five accepted, FULL never drops a byte, OVERFLOW=0; frames back-to-back,
//     no gap.
//  3. Fill FIFO during a frame, then WE 8'hFF while FULL -> byte dropped, OVERFLOW=1 and held;
//     remaining frames are unaffected.
//  4. Assert CLR during the DATA state of 8'h3C -> TX=1 next edge; FIFO empty; BUSY=0;
//     OVERFLOW=0; a new WE 8'h81 transmits cleanly.
//  5. WE exactly on the last STOP cycle of a frame with the FIFO empty -> the next START begins
//     one cycle after IDLE is entered. Frame contents are correct.
//  6. WE with 8'h00 and 8'hFF -> frame bit patterns are all-0 and all-1 data between the correct
//     start and stop bits.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the memory-mapped serial transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_tx_port_sync_fifo.sv
// Small synchronous FIFO with show-ahead output: dout always presents the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_tx_port.sv
// Serial 8N1 transmitter fed by CPU store strobes through a small byte queue.
module serial_tx_port
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  WE,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic                  TX,
    output logic                  FULL,
    output logic                  BUSY,
    output logic                  OVERFLOW
);

    localparam int                IDX_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [7:0]        BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             state;
    tx_state_t             next_state;
    logic [7:0]            baud_cnt;
    logic [7:0]            next_baud;
    logic [IDX_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      next_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] next_shift;
    logic                  overflow_q;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  last_tick;

    // A write while full is dropped; the decision uses the count before this edge.
    assign fifo_push = WE && !fifo_full;
    assign last_tick = (baud_cnt == BAUD_LAST);

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .CLR   (CLR),
        .push  (fifo_push),
        .din   (DATA_IN),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State, baud counter, bit index, shift register and the sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state      <= next_state;
            baud_cnt   <= next_baud;
            bit_idx    <= next_idx;
            shift_reg  <= next_shift;
            overflow_q <= overflow_q | (WE & fifo_full);
        end
    end

    // Frame sequencing; STOP can chain straight into START to keep frames gap-free.
    always_comb begin
        next_state = state;
        next_baud  = baud_cnt + 8'd1;
        next_idx   = bit_idx;
        next_shift = shift_reg;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                next_baud = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    next_shift = fifo_dout;
                    next_idx   = '0;
                    next_state = START;
                end
            end
            START: begin
                if (last_tick) begin
                    next_baud  = '0;
                    next_idx   = '0;
                    next_state = DATA;
                end
            end
            DATA: begin
                if (last_tick) begin
                    next_baud  = '0;
                    next_shift = shift_reg >> 1;
                    if (bit_idx == IDX_LAST) begin
                        next_state = STOP;
                    end else begin
                        next_idx = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (last_tick) begin
                    next_baud = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        next_shift = fifo_dout;
                        next_idx   = '0;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_baud  = '0;
                next_state = IDLE;
            end
        endcase
    end

    // Line level decoded purely from registered state so it never glitches on WE/DATA_IN.
    always_comb begin
        TX = TX_IDLE_LEVEL;
        case (state)
            START:   TX = 1'b0;
            DATA:    TX = shift_reg[0];
            default: TX = TX_IDLE_LEVEL;
        endcase
    end

    assign FULL     = fifo_full;
    assign BUSY     = (state != IDLE) || !fifo_empty;
    assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_serial_tx_port.sv
// Directed self-checking bench for serial_tx_port with 4 clocks per bit and a 4-deep queue.
module tb_serial_tx_port;

    localparam int CPB = 4;

    logic       CLK;
    logic       CLR;
    logic       WE;
    logic [7:0] DATA_IN;
    logic       TX;
    logic       FULL;
    logic       BUSY;
    logic       OVERFLOW;

    int checks;
    int failures;

    serial_tx_port #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .DATA_WIDTH   (8)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .WE       (WE),
        .DATA_IN  (DATA_IN),
        .TX       (TX),
        .FULL     (FULL),
        .BUSY     (BUSY),
        .OVERFLOW (OVERFLOW)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance to just after the next rising edge, where outputs are settled.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    // Present one write (or idle) cycle to the DUT across a single edge.
    task automatic applyStimulus(input logic we, input logic [7:0] data);
        WE      = we;
        DATA_IN = data;
        step();
        WE      = 1'b0;
    endtask

    // Walk frame cycles first..last (cycle 0 is the first START cycle) checking the line level.
    task automatic checkFrame(input logic [7:0] b, input int first, input int last);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = first; i <= last; i++) begin
            checkOutput($sformatf("frame_%02h_tx_c%0d", b, i), TX, frame[i / CPB]);
            if (i == 0 || i == 10 * CPB - 1) begin
                checkOutput($sformatf("frame_%02h_busy_c%0d", b, i), BUSY, 1'b1);
            end
            step();
        end
    endtask

    // Linear sequence of directed scenarios.
    initial begin
        checks   = 0;
        failures = 0;
        CLR      = 1'b1;
        WE       = 1'b0;
        DATA_IN  = 8'h00;

        // Reset state
        step();
        step();
        checkOutput("reset_tx", TX, 1'b1);
        checkOutput("reset_full", FULL, 1'b0);
        checkOutput("reset_busy", BUSY, 1'b0);
        checkOutput("reset_overflow", OVERFLOW, 1'b0);
        CLR = 1'b0;
        step();
        checkOutput("idle_tx", TX, 1'b1);

        // Single byte: queued on the WE edge, line drops one edge later
        $display("[TB] single byte A5");
        applyStimulus(1'b1, 8'hA5);
        checkOutput("t1_tx_after_we", TX, 1'b1);
        checkOutput("t1_busy_after_we", BUSY, 1'b1);
        checkOutput("t1_full_after_we", FULL, 1'b0);
        step();
        checkFrame(8'hA5, 0, 10 * CPB - 1);
        checkOutput("t1_busy_end", BUSY, 1'b0);
        checkOutput("t1_tx_end", TX, 1'b1);

        // Five consecutive writes while idle: first pops at once, the rest fill the queue
        $display("[TB] five back-to-back writes");
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'h02);
        checkOutput("t2_start_c0", TX, 1'b0);
        applyStimulus(1'b1, 8'h03);
        applyStimulus(1'b1, 8'h04);
        applyStimulus(1'b1, 8'h05);
        checkOutput("t2_full", FULL, 1'b1);
        checkOutput("t2_overflow_clear", OVERFLOW, 1'b0);
        checkFrame(8'h01, 3, 10 * CPB - 1);
        checkOutput("t2_full_after_pop", FULL, 1'b0);
        checkFrame(8'h02, 0, 10 * CPB - 1);
        checkFrame(8'h03, 0, 10 * CPB - 1);
        checkFrame(8'h04, 0, 10 * CPB - 1);
        checkFrame(8'h05, 0, 10 * CPB - 1);
        checkOutput("t2_busy_end", BUSY, 1'b0);
        checkOutput("t2_overflow_end", OVERFLOW, 1'b0);

        // Overflow: fill during a frame, then write FF while full
        $display("[TB] overflow while full");
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b1, 8'h22);
        applyStimulus(1'b1, 8'h33);
        applyStimulus(1'b1, 8'h44);
        applyStimulus(1'b1, 8'h55);
        checkOutput("t3_full", FULL, 1'b1);
        checkOutput("t3_overflow_before", OVERFLOW, 1'b0);
        applyStimulus(1'b1, 8'hFF);
        checkOutput("t3_overflow_set", OVERFLOW, 1'b1);
        checkOutput("t3_full_held", FULL, 1'b1);
        checkFrame(8'h11, 4, 10 * CPB - 1);
        checkFrame(8'h22, 0, 10 * CPB - 1);
        checkFrame(8'h33, 0, 10 * CPB - 1);
        checkFrame(8'h44, 0, 10 * CPB - 1);
        checkFrame(8'h55, 0, 10 * CPB - 1);
        checkOutput("t3_busy_end", BUSY, 1'b0);
        checkOutput("t3_tx_end", TX, 1'b1);
        checkOutput("t3_overflow_sticky", OVERFLOW, 1'b1);

        // Reset mid-DATA aborts the frame and flushes the queued byte
        $display("[TB] reset during data");
        applyStimulus(1'b1, 8'h3C);
        applyStimulus(1'b1, 8'h77);
        checkFrame(8'h3C, 0, 3 * CPB + 1);
        CLR = 1'b1;
        step();
        checkOutput("t4_tx_after_clr", TX, 1'b1);
        checkOutput("t4_busy_after_clr", BUSY, 1'b0);
        checkOutput("t4_full_after_clr", FULL, 1'b0);
        checkOutput("t4_overflow_after_clr", OVERFLOW, 1'b0);
        CLR = 1'b0;
        step();
        checkOutput("t4_tx_idle", TX, 1'b1);
        checkOutput("t4_busy_idle", BUSY, 1'b0);
        applyStimulus(1'b1, 8'h81);
        checkOutput("t4_busy_after_we", BUSY, 1'b1);
        step();
        checkFrame(8'h81, 0, 10 * CPB - 1);
        checkOutput("t4_busy_end", BUSY, 1'b0);

        // Write landing on the last STOP cycle with an empty queue: one IDLE cycle, then START
        $display("[TB] write on last stop cycle");
        applyStimulus(1'b1, 8'h5A);
        step();
        checkFrame(8'h5A, 0, 10 * CPB - 2);
        checkOutput("t5_last_stop_tx", TX, 1'b1);
        applyStimulus(1'b1, 8'hC3);
        checkOutput("t5_idle_tx", TX, 1'b1);
        checkOutput("t5_idle_busy", BUSY, 1'b1);
        step();
        checkFrame(8'hC3, 0, 10 * CPB - 1);
        checkOutput("t5_busy_end", BUSY, 1'b0);

        // All-zero and all-one payloads
        $display("[TB] 00 and FF payloads");
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        checkFrame(8'h00, 0, 10 * CPB - 1);
        checkFrame(8'hFF, 0, 10 * CPB - 1);
        checkOutput("t6_tx_end", TX, 1'b1);
        checkOutput("t6_busy_end", BUSY, 1'b0);
        checkOutput("t6_overflow_end", OVERFLOW, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
